// File: rtl/instr_fetch_timing.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_timing
// Purpose  : Instruction-cycle timing and fetch front end for the TB4004 core.
//            It runs the 8-state cycle counter (A1 A2 A3 M1 M2 X1 X2 X3) and
//            owns the program counter. It fetches opcode nibbles at M1/M2,
//            detects two-word opcodes and captures their second byte.
// Ports    : clk          - system clock
//            rstN         - asynchronous active-low reset
//            clkEn        - cycle advance enable (low = every register holds)
//            romData      - ROM nibble for romAddr (high @M1, low @M2)
//            jumpEn       - load pc from jumpAddr at end of X3
//            jumpAddr     - jump target
//            romAddr      - ROM address (equals pc)
//            pc           - program counter
//            cycle        - cycle index 0..7
//            opr, opa     - opcode upper / lower nibble
//            secondWord   - current instruction cycle fetches a second byte
//            operand      - second byte of a two-word instruction
//            operandValid - operand is complete (X1..X3 of a second word)
//            sync         - high while cycle == X3
//            instrDone    - high during X3 of the final word of an instruction
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_timing #(
  parameter int                    PC_WIDTH = 12,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = 12'h000
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                clkEn,
  input  logic [3:0]          romData,
  input  logic                jumpEn,
  input  logic [PC_WIDTH-1:0] jumpAddr,
  output logic [PC_WIDTH-1:0] romAddr,
  output logic [PC_WIDTH-1:0] pc,
  output logic [2:0]          cycle,
  output logic [3:0]          opr,
  output logic [3:0]          opa,
  output logic                secondWord,
  output logic [7:0]          operand,
  output logic                operandValid,
  output logic                sync,
  output logic                instrDone
);

  // Cycle indices within one instruction cycle.
  localparam logic [2:0] CYC_M1 = 3'd3;
  localparam logic [2:0] CYC_M2 = 3'd4;
  localparam logic [2:0] CYC_X1 = 3'd5;
  localparam logic [2:0] CYC_X2 = 3'd6;
  localparam logic [2:0] CYC_X3 = 3'd7;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  logic two_word;
  logic final_word;

  // JCN, FIM (opa[0]==0; odd opa is SRC), JUN, JMS, ISZ carry a second byte.
  always_comb begin
    two_word = 1'b0;
    case (opr)
      4'h1, 4'h4, 4'h5, 4'h7: two_word = 1'b1;
      4'h2:                   two_word = ~opa[0];
      default:                two_word = 1'b0;
    endcase
  end

  // opr/opa are final by X2, so the decision is stable when instrDone is
  // registered at the X2 -> X3 transition.
  assign final_word = secondWord | ~two_word;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cycle      <= 3'd0;
      pc         <= RESET_PC;
      opr        <= 4'h0;
      opa        <= 4'h0;
      operand    <= 8'h00;
      secondWord <= 1'b0;
      instrDone  <= 1'b0;
    end else if (clkEn) begin
      cycle <= cycle + 3'd1;
      case (cycle)
        CYC_M1: begin
          if (secondWord) operand[7:4] <= romData;
          else            opr          <= romData;
        end
        CYC_M2: begin
          if (secondWord) operand[3:0] <= romData;
          else            opa          <= romData;
        end
        CYC_X2: begin
          instrDone <= final_word;
        end
        CYC_X3: begin
          instrDone  <= 1'b0;
          // A second word always clears the flag, so there is no third word.
          secondWord <= ~secondWord & two_word;
          pc         <= jumpEn ? jumpAddr : pc + PC_ONE;
        end
        default: begin
        end
      endcase
    end
  end

  assign romAddr      = pc;
  assign sync         = (cycle == CYC_X3);
  assign operandValid = secondWord & (cycle >= CYC_X1);

endmodule
`default_nettype wire
